// File: rtl/acc16_pkg.sv
// Shared types and widths for the 16-bit burst accumulator.
package acc16_pkg;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

endpackage

// File: rtl/full_adder_16bit.sv
// 16-bit ripple-style adder with carry-in and carry-out; purely combinational.
module full_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    assign sum   = total[15:0];
    assign cout  = total[16];

endmodule

// File: rtl/accumulator_16bit.sv
// Burst accumulator: sums BURST_LEN samples through full_adder_16bit with sticky carry/overflow.
// Optional macro ACC16_SATURATE_EN clamps acc to 16'hFFFF whenever the adder carries out.
module accumulator_16bit
    import acc16_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic             carry,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] sum;
    logic             cout;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] count_inc;
    logic             accept;
    logic             release_hs;
    logic             ovf_now;

    full_adder_16bit u_adder (
        .a    (acc),
        .b    (in_data),
        .cin  (in_cin),
        .sum  (sum),
        .cout (cout)
    );

    assign in_ready   = (state != HOLD) && !rst;
    assign out_valid  = (state == HOLD);
    assign accept     = in_valid && in_ready;
    assign release_hs = out_valid && out_ready;
    assign count_inc  = count + CNT_W'(1);
    assign ovf_now    = (acc[ACC_W-1] == in_data[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef ACC16_SATURATE_EN
    assign acc_next = cout ? {ACC_W{1'b1}} : sum;
`else
    assign acc_next = sum;
`endif

    // The burst ends on the accept that brings count up to BURST_LEN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (count_inc == CNT_W'(BURST_LEN)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && (count_inc == CNT_W'(BURST_LEN))) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (release_hs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            count <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                acc   <= acc_next;
                carry <= carry | cout;
                ovf   <= ovf | ovf_now;
                count <= count_inc;
            end else if (release_hs) begin
                acc   <= '0;
                carry <= 1'b0;
                ovf   <= 1'b0;
                count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_accumulator_16bit.sv
// Directed bench for accumulator_16bit: a BURST_LEN=4 instance and a BURST_LEN=1 instance.
module tb_accumulator_16bit;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] acc;
    logic        carry;
    logic        ovf;
    logic [7:0]  count;

    logic        in_valid1;
    logic        in_ready1;
    logic [15:0] in_data1;
    logic        in_cin1;
    logic        out_valid1;
    logic        out_ready1;
    logic [15:0] acc1;
    logic        carry1;
    logic        ovf1;
    logic [7:0]  count1;

    int compared;
    int mismatched;

    accumulator_16bit #(.BURST_LEN(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .carry     (carry),
        .ovf       (ovf),
        .count     (count)
    );

    accumulator_16bit #(.BURST_LEN(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .in_cin    (in_cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .acc       (acc1),
        .carry     (carry1),
        .ovf       (ovf1),
        .count     (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic c, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_cin    = c;
        out_ready = ordy;
        tick();
    endtask

    logic [15:0] wrapSamples [4];
    logic [15:0] wrapExpect  [4];
    logic [15:0] midExpect   [4];

    initial begin
        compared   = 0;
        mismatched = 0;
        wrapSamples = '{16'h158A, 16'h7095, 16'h52AF, 16'hB903};
`ifdef ACC16_SATURATE_EN
        wrapExpect  = '{16'h158A, 16'h861F, 16'hD8CE, 16'hFFFF};
`else
        wrapExpect  = '{16'h158A, 16'h861F, 16'hD8CE, 16'h91D1};
`endif
        midExpect   = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};

        rst = 1'b1;
        in_valid = 0; in_data = 0; in_cin = 0; out_ready = 0;
        in_valid1 = 0; in_data1 = 0; in_cin1 = 0; out_ready1 = 0;
        tick();
        tick();
        checkOutput("rst_acc", acc, 16'h0000);
        checkOutput("rst_count", {8'd0, count}, 16'd0);
        checkOutput("rst_flags", {14'd0, carry, ovf}, 16'd0);
        checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd0);
        rst = 1'b0;
        #1;
        checkOutput("idle_in_ready", {15'd0, in_ready}, 16'd1);

        $display("[TB] wrapping burst");
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wrap_out_valid_%0d", i), {15'd0, out_valid}, 16'd0);
            applyStimulus(1'b1, wrapSamples[i], 1'b0, 1'b0);
            checkOutput($sformatf("wrap_acc_%0d", i), acc, wrapExpect[i]);
            checkOutput($sformatf("wrap_count_%0d", i), {8'd0, count}, 16'(i + 1));
        end
        checkOutput("wrap_out_valid", {15'd0, out_valid}, 16'd1);
        checkOutput("wrap_carry", {15'd0, carry}, 16'd1);
        checkOutput("wrap_ovf", {15'd0, ovf}, 16'd1);

        $display("[TB] backpressure");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
            checkOutput($sformatf("bp_out_valid_%0d", i), {15'd0, out_valid}, 16'd1);
            checkOutput($sformatf("bp_acc_%0d", i), acc, wrapExpect[3]);
            checkOutput($sformatf("bp_in_ready_%0d", i), {15'd0, in_ready}, 16'd0);
            checkOutput($sformatf("bp_count_%0d", i), {8'd0, count}, 16'd4);
        end
        applyStimulus(1'b1, 16'h1111, 1'b0, 1'b1);
        checkOutput("rel_acc", acc, 16'h0000);
        checkOutput("rel_count", {8'd0, count}, 16'd0);
        checkOutput("rel_flags", {14'd0, carry, ovf}, 16'd0);
        checkOutput("rel_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("rel_in_ready", {15'd0, in_ready}, 16'd1);

        $display("[TB] carry-in accumulation");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0);
            checkOutput($sformatf("cin_acc_%0d", i), acc, 16'(2 * (i + 1)));
        end
        checkOutput("cin_flags", {14'd0, carry, ovf}, 16'd0);
        checkOutput("cin_out_valid", {15'd0, out_valid}, 16'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("cin_rel_acc", acc, 16'h0000);

        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        checkOutput("mid_pre_acc", acc, 16'h0020);
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("mid_acc", acc, 16'h0000);
        checkOutput("mid_count", {8'd0, count}, 16'd0);
        checkOutput("mid_flags", {14'd0, carry, ovf}, 16'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("mid_out_valid_%0d", i), {15'd0, out_valid}, 16'd0);
            applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
            checkOutput($sformatf("mid_acc_%0d", i), acc, midExpect[i]);
        end
        checkOutput("mid_done", {15'd0, out_valid}, 16'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        $display("[TB] single-sample bursts");
        in_valid1 = 1'b1; in_data1 = 16'h7FFF; in_cin1 = 1'b0;
        tick();
        in_valid1 = 1'b0;
        checkOutput("single1_acc", acc1, 16'h7FFF);
        checkOutput("single1_ovf", {15'd0, ovf1}, 16'd0);
        checkOutput("single1_out_valid", {15'd0, out_valid1}, 16'd1);
        checkOutput("single1_count", {8'd0, count1}, 16'd1);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        checkOutput("single_rel_acc", acc1, 16'h0000);
        in_valid1 = 1'b1; in_data1 = 16'h0001;
        tick();
        in_valid1 = 1'b0;
        checkOutput("single2_acc", acc1, 16'h0001);
        checkOutput("single2_ovf", {15'd0, ovf1}, 16'd0);
        checkOutput("single2_out_valid", {15'd0, out_valid1}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/accumulator_16bit.md
# accumulator_16bit

- Sequential accumulator sitting directly downstream of `full_adder_16bit`.
- Accepts a burst of `BURST_LEN` 16-bit samples over a valid/ready handshake.
- For each accepted sample, feeds the running total, the sample and a per-sample carry-in into one `full_adder_16bit` instance, then registers `sum` and tracks `cout` and signed overflow as sticky flags.
- Presents the burst result on an output valid/ready handshake; used wherever the datapath needs multi-sample sums from the 16-bit adder.

## Interface
- `BURST_LEN`, default 4: samples per burst, legal range 1..255.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: sample present.
- `in_ready` output, 1 bit: block can accept a sample.
- `in_data` input, 16 bits: sample, goes to adder operand `b`.
- `in_cin` input, 1 bit: carry-in for this sample, goes to adder `cin`.
- `out_valid` output, 1 bit: burst result valid.
- `out_ready` input, 1 bit: consumer takes the result.
- `acc` output, 16 bits: running total (adder operand `a`) and the burst result.
- `carry` output, 1 bit: sticky OR of adder `cout` over the burst.
- `ovf` output, 1 bit: sticky signed (two's-complement) overflow over the burst.
- `count` output, 8 bits: samples accepted in the current burst.

## Operation
- **States:**
  - IDLE: no sample in burst.
  - ACCUM: 1..`BURST_LEN`-1 samples taken.
  - HOLD: result presented.
- **Ready:** `in_ready` = (state is IDLE or ACCUM) AND NOT `rst`, combinational.
- **Accept:** a sample is accepted when `in_valid` && `in_ready`. On accept, all of the following load at the clock edge:
  - `acc` ← `sum`.
  - `carry` ← `carry` | `cout`.
  - `ovf` ← `ovf` | (`acc[15]` == `in_data[15]` && `sum[15]` != `acc[15]`).
  - `count` ← `count` + 1.
- **Transitions:**
  - IDLE→ACCUM on accept when `BURST_LEN` > 1.
  - ACCUM→HOLD on the accept that makes `count` == `BURST_LEN`.
  - When `BURST_LEN` == 1, IDLE→HOLD directly.
- **HOLD:**
  - `out_valid` = 1.
  - `acc`, `carry`, `ovf` and `count` are frozen.
  - `in_valid` is ignored.
- **Release:** `out_valid` && `out_ready` moves HOLD→IDLE and clears `acc`, `carry`, `ovf` and `count` to 0 at the same edge.
- **Width rule:** all arithmetic is mod 2^16; `cout` is never stored in `acc`.
- **Reset values:** `acc`=0, `carry`=0, `ovf`=0, `count`=0, `out_valid`=0, `in_ready`=0 while `rst`=1, state=IDLE.
- **Reset mid-burst:** `rst` in any state discards the partial burst; the next burst needs a full `BURST_LEN` samples.

## Timing
- An accepted sample is reflected in `acc`/`carry`/`ovf`/`count` one cycle after the accept edge.
- `out_valid` rises in the cycle after the final accept. Burst latency is `BURST_LEN` accept cycles plus 1.
- Maximum throughput is one sample per cycle during the burst.
- The release cycle has `in_ready`=0, so a concurrent `in_valid` is not taken. The earliest next accept is the cycle after release, with `acc`=0.
- `out_valid` is a level held until the handshake, never a pulse. `out_ready` outside HOLD has no effect.
- The adder path is combinational from `acc`/`in_data`/`in_cin` to register inputs, so it is one cycle deep.

## Configuration
- Macro: `ACC16_SATURATE_EN`.
- **Defined:** on an accept with `cout`=1, `acc` ← 16'hFFFF instead of `sum`, and `carry` is still set. Further accepts keep `acc` at 16'hFFFF. `ovf` is computed as usual.
- **Undefined:** `acc` wraps mod 2^16. There is no extra logic.

## Structure
- Package `acc16_pkg` holds:
  - state typedef (IDLE, ACCUM, HOLD);
  - constant `ACC_W` = 16;
  - constant `CNT_W` = 8.
- Exactly one sub-module: the existing `full_adder_16bit`, port mapping `a`=`acc`, `b`=`in_data`, `cin`=`in_cin`, giving `sum` and `cout`.
- The FSM, flags and counter live in this module; there is no other hierarchy.

## Test plan
- **Wrapping burst:** `BURST_LEN`=4, samples 158A, 7095, 52AF, B903, `in_cin`=0, back-to-back → `acc` steps 158A, 861F, D8CE, 91D1. Result: `carry`=1, `ovf`=1, `count`=4, `out_valid` one cycle after the 4th accept.
- **Carry-in accumulation:** 4 samples of 0001 with `in_cin`=1 → `acc` 0002, 0004, 0006, 0008; `carry`=0, `ovf`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `out_valid` stays 1, `acc` stays stable, `in_ready`=0, no accept. Then `out_ready`=1 → next cycle all outputs are 0 and `in_ready`=1.
- **Reset mid-burst:** `rst` pulse after 2 accepts → `acc`/`count`/flags are 0. A further 4 samples are needed before `out_valid`.
- **Saturation (`ACC16_SATURATE_EN` defined):** the first burst gives `acc`=FFFF, `carry`=1.
- **Single-sample bursts:** `BURST_LEN`=1, sample 7FFF then 0001 across two bursts → results 7FFF and 0001, each with `ovf`=0.
